// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//
// Watches a qualified serial bit stream for a programmable PAT_W-bit pattern.
// It is the parametrised successor to the fixed four-ones detector; the
// default parameters still detect four consecutive ones.
//
// Build option: define SEQ_DET_MASK_EN to add pattern_mask_in. The mask is
// latched with pattern_in on pattern_load, and a 0 mask bit makes that
// history position a don't-care. The mask register resets to all-ones.
// Without the macro the port does not exist and every bit is compared.
//
// Handshake: a bit is accepted on a rising clk edge when in_valid is high.
// There is no back-pressure, so every qualified bit is consumed.
// pattern_load takes priority, and a bit presented with it is dropped.
//
// Ports:
//   clk             in   1        rising-edge clock
//   reset           in   1        asynchronous active-high reset
//   data_in         in   1        serial data bit
//   in_valid        in   1        qualifies data_in
//   pattern_in      in   PAT_W    new pattern, MSB is the oldest bit
//   pattern_mask_in in   PAT_W    compare mask (SEQ_DET_MASK_EN only)
//   pattern_load    in   1        strobe: latch pattern, clear history/fill
//   overlap_en      in   1        1 = overlapping, 0 = non-overlapping
//   count_clr       in   1        synchronous clear of det_count/count_sat
//   det             out  1        registered one-cycle match pulse
//   det_count       out  COUNT_W  saturating match count
//   count_sat       out  1        sticky: det_count reached all-ones
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int                PAT_W           = 4,
  parameter logic [PAT_W-1:0]  DEFAULT_PATTERN = PAT_W'(4'b1111),
  parameter int                COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_in,
  input  logic               in_valid,
  input  logic [PAT_W-1:0]   pattern_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0]   pattern_mask_in,
`endif
  input  logic               pattern_load,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               det,
  output logic [COUNT_W-1:0] det_count,
  output logic               count_sat
);

  // The fill counter has to hold the values 0..PAT_W inclusive.
  localparam int                 FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_W);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  history_q;
  logic [PAT_W-1:0]  hist_next;
  logic [PAT_W-1:0]  mask_q;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_next;
  logic              match;

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
    end else if (pattern_load) begin
      mask_q <= pattern_mask_in;
    end
  end
`else
  assign mask_q = '1;
`endif

  // The history and fill values as they would be after accepting data_in.
  // A match is judged on these post-update values.
  always_comb begin
    hist_next = {history_q[PAT_W-2:0], data_in};
    fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match     = in_valid && !pattern_load && (fill_next == FILL_FULL) &&
                (((hist_next ^ pattern_q) & mask_q) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= DEFAULT_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      det       <= 1'b0;
    end else if (pattern_load) begin
      pattern_q <= pattern_in;
      history_q <= '0;
      fill_q    <= '0;
      det       <= 1'b0;
    end else if (in_valid) begin
      det <= match;
      if (match && !overlap_en) begin
        // A non-overlapping match consumes its bits, so the next match
        // needs PAT_W fresh bits.
        history_q <= '0;
        fill_q    <= '0;
      end else begin
        history_q <= hist_next;
        fill_q    <= fill_next;
      end
    end else begin
      det <= 1'b0;
    end
  end

  // Match counter. A clear wins over a coincident match; det still pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_count <= '0;
      count_sat <= 1'b0;
    end else if (count_clr) begin
      det_count <= '0;
      count_sat <= 1'b0;
    end else if (match && (det_count != COUNT_MAX)) begin
      det_count <= det_count + 1'b1;
      if (det_count == COUNT_MAX - 1'b1) begin
        count_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Directed bench for seq_pattern_detector. Two instances share every input:
// dut uses the default parameters and dut3 uses COUNT_W=3 for saturation.
// Each step pushes the det value it expects after the edge into exp_q. After
// the edge it pops that value and compares it with det.
// ---------------------------------------------------------------------------
module tb_seq_pattern_detector;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       data_in      = 1'b0;
  logic       in_valid     = 1'b0;
  logic [3:0] pattern_in   = 4'b0000;
  logic       pattern_load = 1'b0;
  logic       overlap_en   = 1'b1;
  logic       count_clr    = 1'b0;
`ifdef SEQ_DET_MASK_EN
  logic [3:0] pattern_mask_in = 4'b1111;
`endif

  logic       det;
  logic [7:0] det_count;
  logic       count_sat;
  logic       det3;
  logic [2:0] det_count3;
  logic       count_sat3;

  seq_pattern_detector dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .in_valid     (in_valid),
    .pattern_in   (pattern_in),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask_in (pattern_mask_in),
`endif
    .pattern_load (pattern_load),
    .overlap_en   (overlap_en),
    .count_clr    (count_clr),
    .det          (det),
    .det_count    (det_count),
    .count_sat    (count_sat)
  );

  seq_pattern_detector #(.COUNT_W(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .in_valid     (in_valid),
    .pattern_in   (pattern_in),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask_in (pattern_mask_in),
`endif
    .pattern_load (pattern_load),
    .overlap_en   (overlap_en),
    .count_clr    (count_clr),
    .det          (det3),
    .det_count    (det_count3),
    .count_sat    (count_sat3)
  );

  // Scoreboard.
  logic [0:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_det(input string tag);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'd0, det}, {31'd0, e});
    end
  endtask

  // Driver tasks. Inputs change on the falling edge and the checks run 1 ns
  // after the rising edge.
  task automatic step(input logic v, input logic b, input logic clr, input logic e,
                      input string tag);
    @(negedge clk);
    in_valid     = v;
    data_in      = b;
    count_clr    = clr;
    pattern_load = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_det(tag);
  endtask

  // Load a pattern and clear the counters. A valid 1 is presented in the
  // same cycle and must be dropped.
  task automatic prep(input logic [3:0] pat, input string tag);
    @(negedge clk);
    pattern_in   = pat;
    pattern_load = 1'b1;
    count_clr    = 1'b1;
    in_valid     = 1'b1;
    data_in      = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1;
    pop_det(tag);
    check({tag, "_cnt"}, {24'd0, det_count}, 32'd0);
  endtask

  task automatic ones(input int n, input int first_det, input logic ovl, input string tag);
    for (int i = 1; i <= n; i++) begin
      if (ovl) step(1'b1, 1'b1, 1'b0, (i >= first_det), tag);
      else     step(1'b1, 1'b1, 1'b0, (i % first_det == 0), tag);
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    #2;
    check("rst_det", {31'd0, det}, 32'd0);
    check("rst_cnt", {24'd0, det_count}, 32'd0);
    check("rst_sat", {31'd0, count_sat}, 32'd0);
    check("rst_cnt3", {29'd0, det_count3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Four ones on consecutive edges, overlapping.
    overlap_en = 1'b1;
    ones(4, 4, 1'b1, "four_ones");
    step(1'b0, 1'b0, 1'b0, 1'b0, "four_idle");
    check("four_cnt", {24'd0, det_count}, 32'd1);

    // Seven ones, overlapping: det on bits 4..7.
    prep(4'b1111, "prep_ov7");
    ones(7, 4, 1'b1, "ov7");
    step(1'b0, 1'b0, 1'b0, 1'b0, "ov7_idle");
    check("ov7_cnt", {24'd0, det_count}, 32'd4);

    // Seven ones, non-overlapping: det on bit 4 only.
    prep(4'b1111, "prep_no7");
    overlap_en = 1'b0;
    ones(7, 4, 1'b0, "no7");
    check("no7_cnt", {24'd0, det_count}, 32'd1);

    // Eight ones, non-overlapping: det on bits 4 and 8.
    prep(4'b1111, "prep_no8");
    ones(8, 4, 1'b0, "no8");
    step(1'b0, 1'b0, 1'b0, 1'b0, "no8_idle");
    check("no8_cnt", {24'd0, det_count}, 32'd2);

    // Pattern 1011, overlapping, stream 1,0,1,1,0,1,1: det on bits 4 and 7.
    overlap_en = 1'b1;
    prep(4'b1011, "prep_1011");
    step(1'b1, 1'b1, 1'b0, 1'b0, "p1011_b1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "p1011_b2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "p1011_b3");
    step(1'b1, 1'b1, 1'b0, 1'b1, "p1011_b4");
    step(1'b1, 1'b0, 1'b0, 1'b0, "p1011_b5");
    step(1'b1, 1'b1, 1'b0, 1'b0, "p1011_b6");
    step(1'b1, 1'b1, 1'b0, 1'b1, "p1011_b7");
    step(1'b0, 1'b0, 1'b0, 1'b0, "p1011_idle");
    check("p1011_cnt", {24'd0, det_count}, 32'd2);

    // The 1 presented with the load is dropped, so 0,1,1 cannot complete 1011.
    prep(4'b1011, "prep_drop");
    step(1'b1, 1'b0, 1'b0, 1'b0, "drop_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "drop_b2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "drop_b3");
    check("drop_cnt", {24'd0, det_count}, 32'd0);

    // Ones interleaved with idle cycles. data_in toggles while idle.
    prep(4'b1111, "prep_gap");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_v1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_i1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_v2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_i2");
    step(1'b0, 1'b1, 1'b0, 1'b0, "gap_i3");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_v3");
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_i4");
    step(1'b1, 1'b1, 1'b0, 1'b1, "gap_v4");
    step(1'b0, 1'b1, 1'b0, 1'b0, "gap_i5");
    check("gap_cnt", {24'd0, det_count}, 32'd1);

    // Reset mid-stream. Load 0000 first so the ones afterwards only match
    // if reset restored the default pattern.
    prep(4'b0000, "prep_rst");
    ones(3, 99, 1'b1, "rst_pre");
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_det", {31'd0, det}, 32'd0);
    check("rst_mid_cnt", {24'd0, det_count}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "rst_one");
    check("rst_one_cnt", {24'd0, det_count}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "rst_b2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "rst_b3");
    step(1'b1, 1'b1, 1'b0, 1'b1, "rst_b4");

    // A clear coinciding with a match: det pulses and the count reads 0.
    prep(4'b1111, "prep_clr");
    ones(3, 99, 1'b1, "clr_pre");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr_match");
    check("clr_match_cnt", {24'd0, det_count}, 32'd0);

    // Saturation of the COUNT_W=3 instance: twelve ones give 9 matches.
    prep(4'b1111, "prep_sat");
    ones(9, 4, 1'b1, "sat_a");
    check("sat_pre_cnt3", {29'd0, det_count3}, 32'd6);
    check("sat_pre_flag3", {31'd0, count_sat3}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "sat_b10");
    check("sat_reach_cnt3", {29'd0, det_count3}, 32'd7);
    check("sat_reach_flag3", {31'd0, count_sat3}, 32'd1);
    ones(2, 1, 1'b1, "sat_b");
    check("sat_cnt3", {29'd0, det_count3}, 32'd7);
    check("sat_flag3", {31'd0, count_sat3}, 32'd1);
    check("sat_cnt8", {24'd0, det_count}, 32'd9);
    check("sat_flag8", {31'd0, count_sat}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "sat_clr");
    check("sat_clr_cnt3", {29'd0, det_count3}, 32'd0);
    check("sat_clr_flag3", {31'd0, count_sat3}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
